branch_resolve_queue: RTL
=========================

Name: branch_resolve_queue

Overview:
- In-order queue of in-flight branch predictions; sits between the predictor's fetch-side outputs and its training stage.
- Each fetch-time prediction is pushed with the context needed to train the predictor: PC, direction, target, perceptron sum and global history snapshot.
- Execute resolves entries in program order. The block pops the oldest entry and compares it against the actual outcome.
- Emits a registered update packet (train/mispredict) to the weight/BST update logic, plus a flush/redirect with the recovered global history.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
PC_W, 32, PC/target width
SUM_W, 9, signed perceptron sum width
HIST_W, 16, global history snapshot width
THETA, 44, training threshold on |sum|

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
pred_valid  in  1  prediction push request
pred_ready  out  1  queue can accept a push
pred_pc  in  PC_W  fetched branch PC
pred_taken  in  1  predicted direction
pred_target  in  PC_W  predicted target
pred_sum  in  SUM_W  signed perceptron total
pred_ghr  in  HIST_W  history at prediction time
res_valid  in  1  oldest entry resolved this cycle
res_is_branch  in  1  resolved instruction is a conditional branch
res_taken  in  1  actual direction
res_target  in  PC_W  actual taken target
upd_valid  out  1  update packet valid
upd_pc  out  PC_W  PC of resolved entry
upd_taken  out  1  actual direction
upd_target  out  PC_W  actual target
upd_ghr  out  HIST_W  snapshot for weight indexing
upd_train  out  1  train perceptron/bias
upd_mispredict  out  1  prediction wrong
flush  out  1  discard younger fetch state
redirect_pc  out  PC_W  correct fetch PC
recover_ghr  out  HIST_W  repaired history
count  out  $clog2(DEPTH)+1  occupancy
underflow_err  out  1  sticky: resolve with empty queue
stat_branches  out  16  resolved-branch counter
stat_mispredicts  out  16  mispredict counter

Behaviour:
- Single clock clk. Reset rst is asynchronous, active-high.
- On reset: pointers and count = 0; all upd_* = 0; flush = 0; redirect_pc = 0; recover_ghr = 0; underflow_err = 0; stat_* = 0.
- Storage is a circular buffer. head/tail are $clog2(DEPTH)+1 bits with a wrap bit. full = count==DEPTH; empty = count==0.
- pred_ready = !full. It is decoded from registered state only, with no combinational path from res_valid.
- Push occurs when pred_valid && pred_ready. The entry is written at tail; tail increments and wraps naturally.
- Pop occurs when res_valid && !empty. The entry at head is evaluated combinationally; head increments.
- Mispredict on pop:
  - Branch entry (res_is_branch=1): mispredict = (res_taken != taken) || (res_taken && res_target != target).
  - Non-branch entry (res_is_branch=0, BST alias): mispredict = taken, and res_taken is treated as 0.
- Train = res_is_branch && (direction wrong || |sum| <= THETA). |sum| is computed in SUM_W+1 bits, so -256 gives 256.
- Update packet latency is one cycle: outputs are registered on the clock edge after the pop cycle. upd_valid pulses for exactly one cycle per pop.
- Registered packet contents: upd_pc, upd_taken, upd_target (= res_target), upd_ghr (= entry ghr).
- flush is registered with the packet and equals upd_mispredict.
  - redirect_pc = res_taken ? res_target : pc+4, modulo 2^PC_W.
  - recover_ghr = {ghr[HIST_W-2:0], res_taken}.
- Mispredicting pop clears the queue: head=tail=0, count=0 at the same edge. A push in that same cycle is dropped.
- Push and non-mispredicting pop in the same cycle: both take effect, count unchanged. When full, the push is refused because pred_ready=0.
- res_valid while empty: no pop and no packet; underflow_err sets and stays set until reset.
- Reset mid-operation: queue contents are discarded and no packet is emitted.

Optional Feature:
BRANCH_RESOLVE_QUEUE_STATS_EN.
- Defined: stat_branches increments on each pop with res_is_branch=1. stat_mispredicts increments on each mispredicting pop. Both saturate at 16'hFFFF and are updated on the same edge as upd_valid.
- Undefined: no counter logic is built; both ports are tied to 0.

Test Plan:
- Push pc=0x10 taken=1 target=0x40 sum=+100 ghr=0x00F0; resolve taken, target 0x40 -> next cycle upd_valid=1, mispredict=0, train=0, flush=0.
- Push sum=-20 taken=0; resolve not-taken -> upd_train=1 (|−20|<=44), upd_mispredict=0.
- Push pc=0x20 taken=0 ghr=0x0001, plus two younger entries; resolve taken, target 0x80 -> flush=1, redirect_pc=0x80, recover_ghr=0x0003, count=0; a push in the same cycle is dropped.
- Push 4 entries -> pred_ready=0, count=4; a 5th push is ignored; pop+push in one cycle keeps count=4 after pred_ready reasserts.
- res_valid with empty queue -> no upd_valid, underflow_err=1 until rst; assert rst mid-fill (count=3) -> count=0 and all outputs 0 immediately, without waiting for a clock edge.
- With BRANCH_RESOLVE_QUEUE_STATS_EN: 3 branch pops including 1 mispredict -> stat_branches=3, stat_mispredicts=1.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; pops the oldest entry on resolve and emits
// a registered train/mispredict packet plus flush/redirect. BRANCH_RESOLVE_QUEUE_STATS_EN adds counters.
module branch_resolve_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int SUM_W  = 9,
  parameter int HIST_W = 16,
  parameter int THETA  = 44
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pred_valid,
  output logic                    pred_ready,
  input  logic [PC_W-1:0]         pred_pc,
  input  logic                    pred_taken,
  input  logic [PC_W-1:0]         pred_target,
  input  logic [SUM_W-1:0]        pred_sum,
  input  logic [HIST_W-1:0]       pred_ghr,
  input  logic                    res_valid,
  input  logic                    res_is_branch,
  input  logic                    res_taken,
  input  logic [PC_W-1:0]         res_target,
  output logic                    upd_valid,
  output logic [PC_W-1:0]         upd_pc,
  output logic                    upd_taken,
  output logic [PC_W-1:0]         upd_target,
  output logic [HIST_W-1:0]       upd_ghr,
  output logic                    upd_train,
  output logic                    upd_mispredict,
  output logic                    flush,
  output logic [PC_W-1:0]         redirect_pc,
  output logic [HIST_W-1:0]       recover_ghr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    underflow_err,
  output logic [15:0]             stat_branches,
  output logic [15:0]             stat_mispredicts
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              taken;
    logic [PC_W-1:0]   target;
    logic [SUM_W-1:0]  sum;
    logic [HIST_W-1:0] ghr;
  } entry_t;

  entry_t         mem_q [DEPTH];
  logic [AW:0]    head_q, head_d, tail_q, tail_d;
  logic           empty, full, pop, push;
  entry_t         head_e;
  logic           eff_taken, dir_wrong, mispredict, train;
  logic [SUM_W:0] sum_ext, sum_abs;

  // Occupancy comes from the wrap-bit pointers, so pred_ready depends on registered state only.
  assign count      = tail_q - head_q;
  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign pred_ready = !full;
  assign pop        = res_valid && !empty;
  assign head_e     = mem_q[head_q[AW-1:0]];

  // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
  always_comb begin
    eff_taken  = res_is_branch && res_taken;
    dir_wrong  = (eff_taken != head_e.taken);
    mispredict = res_is_branch ? (dir_wrong || (res_taken && (res_target != head_e.target)))
                               : head_e.taken;
    sum_ext    = {head_e.sum[SUM_W-1], head_e.sum};
    sum_abs    = sum_ext[SUM_W] ? -sum_ext : sum_ext;
    train      = res_is_branch && (dir_wrong || (sum_abs <= (SUM_W+1)'(THETA)));
    push       = pred_valid && pred_ready && !(pop && mispredict);
    head_d     = head_q;
    tail_d     = tail_q;
    if (pop)  head_d = head_q + (AW+1)'(1);
    if (push) tail_d = tail_q + (AW+1)'(1);
    if (pop && mispredict) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q[AW-1:0]] <= '{pc: pred_pc, taken: pred_taken, target: pred_target,
                                 sum: pred_sum, ghr: pred_ghr};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_target     <= '0;
      upd_ghr        <= '0;
      upd_train      <= 1'b0;
      upd_mispredict <= 1'b0;
      flush          <= 1'b0;
      redirect_pc    <= '0;
      recover_ghr    <= '0;
      underflow_err  <= 1'b0;
    end else begin
      upd_valid      <= pop;
      upd_train      <= pop && train;
      upd_mispredict <= pop && mispredict;
      flush          <= pop && mispredict;
      underflow_err  <= underflow_err || (res_valid && empty);
      if (pop) begin
        upd_pc      <= head_e.pc;
        upd_taken   <= eff_taken;
        upd_target  <= res_target;
        upd_ghr     <= head_e.ghr;
        redirect_pc <= eff_taken ? res_target : head_e.pc + PC_W'(4);
        recover_ghr <= {head_e.ghr[HIST_W-2:0], eff_taken};
      end
    end
  end

`ifdef BRANCH_RESOLVE_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (pop) begin
      if (res_is_branch && (stat_branches != 16'hFFFF)) stat_branches <= stat_branches + 16'd1;
      if (mispredict && (stat_mispredicts != 16'hFFFF)) stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
